apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

Parametrised APB master controller for the AHB-to-APB bridge: it takes decoded AHB transfers from the AHB slave interface and runs them as APB3/APB4 transfers with wait states, byte strobes and error reporting. It generalises the fixed 32-bit, three-slave controller to configurable address/data width and slave count. It adds PREADY wait states, PSLVERR-to-HRESP error mapping, PSTRB generation, decode-error handling and an optional access timeout.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; 32 or 64 only
- NUM_SLV, 3, number of APB slaves (psel width)
- TIMEOUT, 16, maximum ACCESS cycles; only used with APB_TIMEOUT_EN; must be ≥2
- hclk  in  1  clock; everything is on the rising edge
- hreset  in  1  asynchronous, active-high reset
- valid  in  1  decoded AHB transfer (NONSEQ/SEQ) in the address phase
- hreadyin  in  1  AHB HREADY; a transfer is accepted only when valid && hreadyin
- hwrite  in  1  transfer direction
- haddr  in  ADDR_W  transfer address
- hsize  in  3  AHB HSIZE
- hwdata  in  DATA_W  write data, valid in the data phase
- sel_in  in  NUM_SLV  one-hot slave decode of haddr
- hreadyout  out  1  AHB HREADYOUT
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  DATA_W  read data
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pwrite  out  1  APB direction
- pstrb  out  DATA_W/8  APB4 write strobes
- psel  out  NUM_SLV  one-hot APB select
- penable  out  1  APB enable
- pready  in  1  APB ready
- prdata  in  DATA_W  muxed APB read data
- pslverr  in  1  APB slave error

## Operation
- States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- All outputs are registered and loaded from the next-state decode, so each value listed holds for the whole time the FSM is in that state.
- **Accept rule.** In IDLE or ERR2, when valid && hreadyin, latch haddr, hwrite, hsize and sel_in. The next state is:
  - ERR1 if sel_in is not one-hot (zero or multi-hot), or if hsize > log2(DATA_W/8). These are decode errors and no APB cycle is run.
  - WDATA for a write.
  - SETUP for a read.
  - Otherwise (no transfer accepted) go to IDLE.
- **IDLE:** hreadyout=1, hresp=0, psel=0, penable=0.
- **WDATA:** capture hwdata into pwdata. hreadyout=0, psel=0. Next state is SETUP.
- **SETUP:** psel=latched sel, penable=0, hreadyout=0. paddr, pwrite and pstrb are stable from here until the APB transfer ends. Next state is ACCESS.
- **ACCESS:** penable=1, with psel, paddr, pwdata, pwrite and pstrb held.
  - pready=0: stay in ACCESS.
  - pready=1, pslverr=0: go to IDLE; on a read, load hrdata from prdata.
  - pready=1, pslverr=1: go to ERR1; hrdata is not updated.
- **ERR1:** hreadyout=0, hresp=1, psel=0, penable=0. Next state is ERR2.
- **ERR2:** hreadyout=1, hresp=1. Applies the accept rule.
- **pstrb (writes):** lanes covered by 2^hsize bytes, starting at haddr[log2(DATA_W/8)-1:0] and aligned down to the transfer size. Reads drive pstrb=0.
- **hrdata:** holds its last value until the next successful read.
- **Reset:** asserting hreset at any time, including mid-ACCESS, immediately forces state to IDLE and drives:
  - paddr, pwdata, pwrite, pstrb, psel, penable, hresp and hrdata to 0;
  - hreadyout to 1.

## Timing
- Read with zero wait states: accepted in cycle 0; SETUP in cycle 1; ACCESS in cycle 2; IDLE with hreadyout=1 and hrdata valid in cycle 3.
- Write with zero wait states: accepted in cycle 0; WDATA in cycle 1; SETUP in cycle 2; ACCESS in cycle 3; hreadyout=1 in cycle 4.
- Each cycle with pready=0 adds one cycle of latency.
- Back-to-back transfers: the next transfer is accepted in the IDLE or ERR2 cycle that completes the previous one, with no extra bubble.
- A decode error takes 2 cycles (ERR1, then ERR2) after acceptance.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT) clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - If it reaches TIMEOUT-1 while pready=0, the FSM goes to ERR1, drops psel and penable, and ignores any later pready.
- APB_TIMEOUT_EN undefined: ACCESS waits indefinitely and TIMEOUT is unused.

## Structure
- Package ahb_apb_pkg holds:
  - the state enum;
  - HRESP_OKAY/HRESP_ERROR;
  - HSIZE_BYTE/HALF/WORD/DWORD;
  - the DATA_W legality check.
- One sub-module, apb_strb_gen, produces pstrb from hsize, the low address bits and hwrite.

## Test plan
- Read, NUM_SLV=3, sel_in=3'b010, haddr=0x0000_2000, pready=1 at once, prdata=0xDEAD_BEEF -> psel=3'b010 in cycles 1-2, penable only in cycle 2, hrdata=0xDEAD_BEEF with hreadyout=1 in cycle 3.
- Write, haddr=0x0000_1006, hsize=1, hwdata=0xABCD_1234, with 2 wait states -> pstrb=4'b1100, pwdata=0xABCD_1234 stable through 3 ACCESS cycles, hreadyout=1 in cycle 6.
- Read with pslverr=1 on completion -> hresp=1 for 2 cycles, hreadyout 0 then 1, hrdata unchanged.
- sel_in=3'b000 or 3'b011 -> no psel activity, two-cycle ERROR response.
- APB_TIMEOUT_EN, TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then ERR1/ERR2; without the macro, still in ACCESS after 100 cycles.
- Assert hreset in the second ACCESS cycle -> same-cycle psel=0, penable=0, hreadyout=1; after release, a read completes normally.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: FSM states, AHB response and size codes, and the data-width legality
// check shared by the APB master controller files.
package ahb_apb_pkg;
   typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_e;
   localparam logic HRESP_OKAY = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;
   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;
   function automatic bit data_w_ok(int w);
      return w == 32 || w == 64;
   endfunction
endpackage

// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: AHB-side transfer signals and APB bus signals of the APB master
// controller; master is the controller's view, slave is the environment's view.
interface apb_master_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NUM_SLV = 3
);
   logic valid;
   logic hreadyin;
   logic hwrite;
   logic [ADDR_W-1:0] haddr;
   logic [2:0] hsize;
   logic [DATA_W-1:0] hwdata;
   logic [NUM_SLV-1:0] sel_in;
   logic hreadyout;
   logic hresp;
   logic [DATA_W-1:0] hrdata;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic pwrite;
   logic [DATA_W/8-1:0] pstrb;
   logic [NUM_SLV-1:0] psel;
   logic penable;
   logic pready;
   logic [DATA_W-1:0] prdata;
   logic pslverr;
   modport master (
      input valid, hreadyin, hwrite, haddr, hsize, hwdata, sel_in, pready, prdata, pslverr,
      output hreadyout, hresp, hrdata, paddr, pwdata, pwrite, pstrb, psel, penable
   );
   modport slave (
      output valid, hreadyin, hwrite, haddr, hsize, hwdata, sel_in, pready, prdata, pslverr,
      input hreadyout, hresp, hrdata, paddr, pwdata, pwrite, pstrb, psel, penable
   );
endinterface

// File: rtl/apb_strb_gen.sv
// apb_strb_gen: APB4 write strobes covering 2^hsize bytes at the size-aligned low address;
// reads produce no strobes.
module apb_strb_gen #(
   parameter int DATA_W = 32
) (
   input  logic [2:0] hsize_i,
   input  logic [$clog2(DATA_W/8)-1:0] addr_i,
   input  logic hwrite_i,
   output logic [DATA_W/8-1:0] strb_o
);
   localparam int NB = DATA_W / 8;
   localparam int LW = $clog2(NB);
   int bytes;
   logic [LW-1:0] base;
   assign bytes = 1 << hsize_i;
   assign base = addr_i & ~LW'(bytes - 1);
   always_comb begin
      strb_o = '0;
      for (int i = 0; i < NB; i++)
         strb_o[i] = hwrite_i && i >= int'(base) && i < int'(base) + bytes;
   end
endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: runs decoded AHB transfers as APB3/APB4 transfers with wait states,
// strobes and error mapping; APB_TIMEOUT_EN adds an ACCESS-phase timeout.
module apb_master_ctrl
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NUM_SLV = 3,
   parameter int TIMEOUT = 16
) (
   input  logic hclk,
   input  logic hreset,
   apb_master_ctrl_if.master bus
);
   localparam int NB = DATA_W / 8;
   localparam int LW = $clog2(NB);
   localparam bit DW_OK = data_w_ok(DATA_W);
   localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? HSIZE_DWORD : HSIZE_WORD;
   state_e state_q, state_d;
   logic [NUM_SLV-1:0] sel_q, sel_d, psel_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q, hrdata_q;
   logic [NB-1:0] pstrb_q, strb;
   logic pwrite_q, penable_q, hreadyout_q, hresp_q;
   logic accept, dec_err, load, busy_d, rd_ok, tmo_hit;
   apb_strb_gen #(.DATA_W(DATA_W)) u_strb (
      .hsize_i(bus.hsize),
      .addr_i(bus.haddr[LW-1:0]),
      .hwrite_i(bus.hwrite),
      .strb_o(strb)
   );
   assign accept = (state_q == S_IDLE || state_q == S_ERR2) && bus.valid && bus.hreadyin;
   assign dec_err = !$onehot(bus.sel_in) || bus.hsize > MAX_SIZE || !DW_OK;
   assign load = accept && !dec_err;
   assign sel_d = load ? bus.sel_in : sel_q;
   assign busy_d = state_d == S_SETUP || state_d == S_ACCESS;
   assign rd_ok = state_q == S_ACCESS && bus.pready && !bus.pslverr && !pwrite_q;
`ifdef APB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0] tmo_q;
   // Counts stalled ACCESS cycles; zero on the first ACCESS cycle of every transfer.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) tmo_q <= '0;
      else tmo_q <= (state_q != S_ACCESS) ? '0 : tmo_q + TW'(!bus.pready);
   end
   assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
`else
   assign tmo_hit = 1'b0 && (TIMEOUT > 1);
`endif
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) state_q <= S_IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_ERR2: state_d = !accept ? S_IDLE : dec_err ? S_ERR1 : bus.hwrite ? S_WDATA : S_SETUP;
         S_WDATA: state_d = S_SETUP;
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: state_d = bus.pready ? (bus.pslverr ? S_ERR1 : S_IDLE) : (tmo_hit ? S_ERR1 : S_ACCESS);
         S_ERR1: state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end
   // Outputs are decoded from the next state so each holds for the whole state.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         sel_q <= '0;
         paddr_q <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         pstrb_q <= '0;
         psel_q <= '0;
         penable_q <= 1'b0;
         hreadyout_q <= 1'b1;
         hresp_q <= HRESP_OKAY;
         hrdata_q <= '0;
      end else begin
         sel_q <= sel_d;
         psel_q <= busy_d ? sel_d : '0;
         penable_q <= state_d == S_ACCESS;
         hreadyout_q <= state_d == S_IDLE || state_d == S_ERR2;
         hresp_q <= (state_d == S_ERR1 || state_d == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
         if (load) begin
            paddr_q <= bus.haddr;
            pwrite_q <= bus.hwrite;
            pstrb_q <= strb;
         end
         if (state_q == S_WDATA) pwdata_q <= bus.hwdata;
         if (rd_ok) hrdata_q <= bus.prdata;
      end
   end
   assign bus.paddr = paddr_q;
   assign bus.pwdata = pwdata_q;
   assign bus.pwrite = pwrite_q;
   assign bus.pstrb = pstrb_q;
   assign bus.psel = psel_q;
   assign bus.penable = penable_q;
   assign bus.hreadyout = hreadyout_q;
   assign bus.hresp = hresp_q;
   assign bus.hrdata = hrdata_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed spec scenarios plus randomized back-to-back transfers
// checked against a cycle-count model of the APB master controller.
module tb_apb_master_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_hrdata = '0;
   apb_master_ctrl_if bus ();
   apb_master_ctrl #(.TIMEOUT(4)) dut (.hclk(clk), .hreset(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      bus.valid = 1'b0;
      bus.hreadyin = 1'b1;
      bus.hwrite = 1'b0;
      bus.haddr = '0;
      bus.hsize = '0;
      bus.hwdata = '0;
      bus.sel_in = '0;
      bus.pready = 1'b0;
      bus.prdata = '0;
      bus.pslverr = 1'b0;
   endtask
   task automatic req(input bit w, input logic [31:0] a, input logic [2:0] sz, input logic [2:0] sel);
      bus.valid = 1'b1;
      bus.hreadyin = 1'b1;
      bus.hwrite = w;
      bus.haddr = a;
      bus.hsize = sz;
      bus.sel_in = sel;
   endtask
   task automatic test_reset();
      logic [105:0] z;
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      z = {bus.paddr, bus.pwdata, bus.pwrite, bus.pstrb, bus.psel, bus.penable, bus.hresp, bus.hrdata};
      checks++; if (z !== '0) begin errors++; $display("FAIL reset_zero: got %h want 0", z); end
      checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.hreadyout); end
      rst = 1'b0;
      step();
      checks++; if ({bus.hreadyout, bus.psel, bus.penable} !== 5'b10000) begin errors++; $display("FAIL reset_idle: got %b want 10000", {bus.hreadyout, bus.psel, bus.penable}); end
      exp_hrdata = '0;
   endtask
   task automatic test_read();
      logic [79:0] got, want;
      req(1'b0, 32'h0000_2000, 3'd2, 3'b010);
      step();
      bus.valid = 1'b0;
      bus.pready = 1'b1;
      bus.prdata = 32'hDEAD_BEEF;
      got = 80'({bus.hreadyout, bus.psel, bus.penable, bus.paddr}); want = 80'({1'b0, 3'b010, 1'b0, 32'h0000_2000});
      checks++; if (got !== want) begin errors++; $display("FAIL rd_setup: got %h want %h", got, want); end
      step();
      got = 80'({bus.hreadyout, bus.psel, bus.penable}); want = 80'({1'b0, 3'b010, 1'b1});
      checks++; if (got !== want) begin errors++; $display("FAIL rd_access: got %h want %h", got, want); end
      step();
      bus.pready = 1'b0;
      exp_hrdata = 32'hDEAD_BEEF;
      got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.hrdata}); want = 80'({1'b1, 1'b0, 3'b000, 1'b0, exp_hrdata});
      checks++; if (got !== want) begin errors++; $display("FAIL rd_done: got %h want %h", got, want); end
   endtask
   task automatic test_write();
      logic [79:0] got, want;
      req(1'b1, 32'h0000_1006, 3'd1, 3'b100);
      step();
      bus.valid = 1'b0;
      bus.hwdata = 32'hABCD_1234;
      got = 80'({bus.hreadyout, bus.psel, bus.penable}); want = 80'({1'b0, 3'b000, 1'b0});
      checks++; if (got !== want) begin errors++; $display("FAIL wr_wdata: got %h want %h", got, want); end
      step();
      bus.hwdata = 32'h5555_0000;
      got = 80'({bus.psel, bus.penable, bus.pwrite, bus.pstrb, bus.pwdata, bus.paddr}); want = 80'({3'b100, 1'b0, 1'b1, 4'b1100, 32'hABCD_1234, 32'h0000_1006});
      checks++; if (got !== want) begin errors++; $display("FAIL wr_setup: got %h want %h", got, want); end
      for (int c = 3; c <= 5; c++) begin
         step();
         bus.pready = c == 5;
         got = 80'({bus.hreadyout, bus.psel, bus.penable, bus.pstrb, bus.pwdata}); want = 80'({1'b0, 3'b100, 1'b1, 4'b1100, 32'hABCD_1234});
         checks++; if (got !== want) begin errors++; $display("FAIL wr_access%0d: got %h want %h", c, got, want); end
      end
      step();
      bus.pready = 1'b0;
      got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.hrdata}); want = 80'({1'b1, 1'b0, 3'b000, 1'b0, exp_hrdata});
      checks++; if (got !== want) begin errors++; $display("FAIL wr_done: got %h want %h", got, want); end
   endtask
   task automatic test_slverr();
      logic [79:0] got, want;
      req(1'b0, 32'h0000_0100, 3'd2, 3'b001);
      step();
      bus.valid = 1'b0;
      step();
      bus.pready = 1'b1;
      bus.pslverr = 1'b1;
      bus.prdata = 32'h1234_5678;
      checks++; if (bus.penable !== 1'b1) begin errors++; $display("FAIL err_access: got %b want 1", bus.penable); end
      step();
      bus.pready = 1'b0;
      bus.pslverr = 1'b0;
      got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable}); want = 80'({1'b0, 1'b1, 3'b000, 1'b0});
      checks++; if (got !== want) begin errors++; $display("FAIL err_err1: got %h want %h", got, want); end
      step();
      got = 80'({bus.hreadyout, bus.hresp, bus.hrdata}); want = 80'({1'b1, 1'b1, exp_hrdata});
      checks++; if (got !== want) begin errors++; $display("FAIL err_err2: got %h want %h", got, want); end
      step();
      checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) begin errors++; $display("FAIL err_idle: got %b want 10", {bus.hreadyout, bus.hresp}); end
   endtask
   task automatic test_decode_err();
      logic [79:0] got, want;
      logic [2:0] s, z;
      for (int k = 0; k < 3; k++) begin
         s = (k == 0) ? 3'b000 : (k == 1) ? 3'b011 : 3'b001;
         z = (k == 2) ? 3'd3 : 3'd2;
         req(k[0], 32'h0000_0040, z, s);
         step();
         bus.valid = 1'b0;
         got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable}); want = 80'({1'b0, 1'b1, 3'b000, 1'b0});
         checks++; if (got !== want) begin errors++; $display("FAIL dec%0d_err1: got %h want %h", k, got, want); end
         step();
         got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.hrdata}); want = 80'({1'b1, 1'b1, 3'b000, 1'b0, exp_hrdata});
         checks++; if (got !== want) begin errors++; $display("FAIL dec%0d_err2: got %h want %h", k, got, want); end
         step();
         got = 80'({bus.hreadyout, bus.hresp, bus.psel}); want = 80'({1'b1, 1'b0, 3'b000});
         checks++; if (got !== want) begin errors++; $display("FAIL dec%0d_idle: got %h want %h", k, got, want); end
      end
   endtask
   task automatic test_timeout();
      logic [79:0] got, want;
      req(1'b0, 32'h0000_0080, 3'd2, 3'b001);
      step();
      bus.valid = 1'b0;
      bus.pready = 1'b0;
`ifdef APB_TIMEOUT_EN
      for (int c = 2; c <= 5; c++) begin
         step();
         got = 80'({bus.psel, bus.penable}); want = 80'({3'b001, 1'b1});
         checks++; if (got !== want) begin errors++; $display("FAIL tmo_access%0d: got %h want %h", c, got, want); end
      end
      step();
      bus.pready = 1'b1;
      bus.prdata = 32'hCAFE_F00D;
      got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable}); want = 80'({1'b0, 1'b1, 3'b000, 1'b0});
      checks++; if (got !== want) begin errors++; $display("FAIL tmo_err1: got %h want %h", got, want); end
      step();
      bus.pready = 1'b0;
      got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.hrdata}); want = 80'({1'b1, 1'b1, 3'b000, 1'b0, exp_hrdata});
      checks++; if (got !== want) begin errors++; $display("FAIL tmo_err2: got %h want %h", got, want); end
      step();
`else
      for (int c = 2; c <= 101; c++) begin
         step();
         got = 80'({bus.hreadyout, bus.psel, bus.penable}); want = 80'({1'b0, 3'b001, 1'b1});
         checks++; if (got !== want) begin errors++; $display("FAIL tmo_wait%0d: got %h want %h", c, got, want); end
      end
      bus.pready = 1'b1;
      bus.prdata = 32'hCAFE_F00D;
      step();
      bus.pready = 1'b0;
      exp_hrdata = 32'hCAFE_F00D;
      got = 80'({bus.hreadyout, bus.hresp, bus.hrdata}); want = 80'({1'b1, 1'b0, exp_hrdata});
      checks++; if (got !== want) begin errors++; $display("FAIL tmo_release: got %h want %h", got, want); end
`endif
   endtask
   task automatic test_reset_mid_access();
      logic [79:0] got, want;
      req(1'b0, 32'h0000_3000, 3'd2, 3'b100);
      step();
      bus.valid = 1'b0;
      step();
      step();
      checks++; if (bus.penable !== 1'b1) begin errors++; $display("FAIL rst_pre: got %b want 1", bus.penable); end
      #2 rst = 1'b1;
      #1;
      exp_hrdata = '0;
      got = 80'({bus.psel, bus.penable, bus.hreadyout, bus.hresp, bus.hrdata}); want = 80'({3'b000, 1'b0, 1'b1, 1'b0, exp_hrdata});
      checks++; if (got !== want) begin errors++; $display("FAIL rst_mid: got %h want %h", got, want); end
      #2 rst = 1'b0;
      step();
      req(1'b0, 32'h0000_3004, 3'd2, 3'b010);
      step();
      bus.valid = 1'b0;
      bus.pready = 1'b1;
      bus.prdata = 32'h0BAD_F00D;
      step();
      step();
      bus.pready = 1'b0;
      exp_hrdata = 32'h0BAD_F00D;
      got = 80'({bus.hreadyout, bus.hresp, bus.hrdata}); want = 80'({1'b1, 1'b0, exp_hrdata});
      checks++; if (got !== want) begin errors++; $display("FAIL rst_after_read: got %h want %h", got, want); end
   endtask
   // Model: a legal transfer occupies (write ? 4 : 3) + waits cycles, SETUP at cycle 1 or 2.
   task automatic test_random();
      logic [79:0] got, want;
      bit w, err, bad;
      int sz, waits, lat, s, k;
      logic [31:0] a, d, rd;
      logic [2:0] sel;
      logic [3:0] es;
      for (int t = 0; t < 200; t++) begin
         w = 1'($urandom_range(0, 1));
         a = $urandom;
         sz = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
         k = int'($urandom_range(0, 7));
         sel = (k == 0) ? 3'b000 : (k == 1) ? 3'b110 : 3'(1 << $urandom_range(0, 2));
         bad = $countones(sel) != 1 || sz > 2;
         waits = int'($urandom_range(0, 3));
         err = $urandom_range(0, 4) == 0;
         d = $urandom;
         rd = $urandom;
         es = '0;
         for (int i = 0; i < 4; i++) if (w && (i >> sz) == (int'(a[1:0]) >> sz)) es[i] = 1'b1;
         req(w, a, 3'(sz), sel);
         bus.hwdata = $urandom;
         checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL rnd%0d_accept: got %b want 1", t, bus.hreadyout); end
         step();
         bus.valid = 1'b0;
         bus.haddr = $urandom;
         bus.hsize = 3'($urandom_range(0, 7));
         bus.sel_in = 3'($urandom);
         bus.hwrite = 1'($urandom);
         if (bad) begin
            got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable}); want = 80'({1'b0, 1'b1, 3'b000, 1'b0});
            checks++; if (got !== want) begin errors++; $display("FAIL rnd%0d_dec1: got %h want %h", t, got, want); end
            step();
            got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.hrdata}); want = 80'({1'b1, 1'b1, 3'b000, 1'b0, exp_hrdata});
            checks++; if (got !== want) begin errors++; $display("FAIL rnd%0d_dec2: got %h want %h", t, got, want); end
         end else begin
            lat = (w ? 4 : 3) + waits;
            s = w ? 2 : 1;
            for (int c = 1; c < lat; c++) begin
               bus.hwdata = (w && c == 1) ? d : $urandom;
               bus.pready = c == lat - 1;
               bus.pslverr = err && c == lat - 1;
               bus.prdata = (c == lat - 1) ? rd : $urandom;
               if (c >= s) begin
                  got = {bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.pwrite, bus.pstrb, bus.paddr, w ? bus.pwdata : 32'h0, 4'h0};
                  want = {1'b0, 1'b0, sel, c > s, w, es, a, w ? d : 32'h0, 4'h0};
               end else begin
                  got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable});
                  want = 80'({1'b0, 1'b0, 3'b000, 1'b0});
               end
               checks++; if (got !== want) begin errors++; $display("FAIL rnd%0d_c%0d: got %h want %h", t, c, got, want); end
               step();
            end
            bus.pready = 1'b0;
            bus.pslverr = 1'b0;
            if (err) begin
               got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable}); want = 80'({1'b0, 1'b1, 3'b000, 1'b0});
               checks++; if (got !== want) begin errors++; $display("FAIL rnd%0d_slv1: got %h want %h", t, got, want); end
               step();
               got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.hrdata}); want = 80'({1'b1, 1'b1, 3'b000, 1'b0, exp_hrdata});
               checks++; if (got !== want) begin errors++; $display("FAIL rnd%0d_slv2: got %h want %h", t, got, want); end
            end else begin
               if (!w) exp_hrdata = rd;
               got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable, bus.hrdata}); want = 80'({1'b1, 1'b0, 3'b000, 1'b0, exp_hrdata});
               checks++; if (got !== want) begin errors++; $display("FAIL rnd%0d_done: got %h want %h", t, got, want); end
            end
         end
         repeat ($urandom_range(0, 2)) begin
            bus.valid = 1'($urandom);
            bus.hreadyin = 1'b0;
            step();
            got = 80'({bus.hreadyout, bus.hresp, bus.psel, bus.penable}); want = 80'({1'b1, 1'b0, 3'b000, 1'b0});
            checks++; if (got !== want) begin errors++; $display("FAIL rnd%0d_gap: got %h want %h", t, got, want); end
         end
         bus.valid = 1'b0;
         bus.hreadyin = 1'b1;
      end
   endtask
   initial begin
      test_reset();
      test_read();
      test_write();
      test_slverr();
      test_decode_err();
      test_timeout();
      test_reset_mid_access();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
